// File: rtl/btn_pkg.sv
// Shared defaults and counter-width helper for the multi-channel button debouncer.
package btn_pkg;

  localparam int unsigned DEBOUNCE_DEFAULT = 65536;
  localparam int unsigned SYNC_DEFAULT     = 2;

  // Width needed to hold values 0..v-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/button_debouncer_multi_channel.sv
// One debounced button: input synchroniser, symmetric debounce counter,
// registered press/release pulses and an optional long-press detector.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CLK_CNT   = DEBOUNCE_DEFAULT,
  parameter int unsigned SYNC_STAGES        = SYNC_DEFAULT,
  parameter bit          ACTIVE_LOW         = 1'b0,
  parameter int unsigned LONG_PRESS_CLK_CNT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  if (DEBOUNCE_CLK_CNT < 2 || SYNC_STAGES < 2) begin : g_param_err
    $error("debounce_channel: DEBOUNCE_CLK_CNT and SYNC_STAGES must be >= 2");
  end

  localparam int unsigned CW = clog2_min1(DEBOUNCE_CLK_CNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CLK_CNT - 1);

  logic                   lvl;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CW-1:0]          cnt;

  assign lvl = btn ^ ACTIVE_LOW;
  assign s   = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync          <= '0;
      cnt           <= '0;
      state         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync          <= {sync[SYNC_STAGES-2:0], lvl};
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (s == state) begin
        cnt <= '0;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end else begin
        // Pulses are registered alongside the level so they coincide with it.
        state         <= s;
        cnt           <= '0;
        press_pulse   <= s;
        release_pulse <= ~s;
      end
    end
  end

  if (LONG_PRESS_CLK_CNT > 0) begin : g_long
    localparam int unsigned   LW       = clog2_min1(LONG_PRESS_CLK_CNT + 1);
    localparam logic [LW-1:0] LMAX     = LW'(LONG_PRESS_CLK_CNT);
    localparam logic [LW-1:0] LMAX_M1  = LW'(LONG_PRESS_CLK_CNT - 1);

    logic [LW-1:0] lcnt;
    logic          lp;

    // Saturation at LMAX is what keeps btn_long from repeating while held.
    always_ff @(posedge clk) begin
      if (reset) begin
        lcnt <= '0;
        lp   <= 1'b0;
      end else begin
        lp <= 1'b0;
        if (!state) begin
          lcnt <= '0;
        end else if (lcnt < LMAX) begin
          lcnt <= lcnt + LW'(1);
          lp   <= (lcnt == LMAX_M1);
        end
      end
    end

    assign long_pulse = lp;
  end else begin : g_no_long
    assign long_pulse = 1'b0;
  end

endmodule

// File: rtl/button_debouncer_multi.sv
// NUM_BTNS independent debounced buttons with press/release/long-press pulses.
module button_debouncer_multi
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTNS           = 4,
  parameter int unsigned DEBOUNCE_CLK_CNT   = DEBOUNCE_DEFAULT,
  parameter int unsigned SYNC_STAGES        = SYNC_DEFAULT,
  parameter bit          ACTIVE_LOW         = 1'b0,
  parameter int unsigned LONG_PRESS_CLK_CNT = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btn_in,
  output logic [NUM_BTNS-1:0] btn_state,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release,
  output logic [NUM_BTNS-1:0] btn_long
);

  if (NUM_BTNS < 1) begin : g_param_err
    $error("button_debouncer_multi: NUM_BTNS must be >= 1");
  end

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CLK_CNT  (DEBOUNCE_CLK_CNT),
      .SYNC_STAGES       (SYNC_STAGES),
      .ACTIVE_LOW        (ACTIVE_LOW),
      .LONG_PRESS_CLK_CNT(LONG_PRESS_CLK_CNT)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .btn          (btn_in[i]),
      .state        (btn_state[i]),
      .press_pulse  (btn_press[i]),
      .release_pulse(btn_release[i]),
      .long_pulse   (btn_long[i])
    );
  end

endmodule

// File: doc/button_debouncer_multi.md
Name: button_debouncer_multi

Overview:
Parametrised multi-channel successor to the single-button debouncer. Debounces NUM_BTNS asynchronous button inputs independently, in both directions (press and release). Each channel has its own input synchroniser and polarity handling, and emits one-cycle press, release and long-press pulses. Sits between board pins and the user-interface logic; all outputs are synchronous to clk.

Parameters:
NUM_BTNS, 4, number of independent channels (>=1)
DEBOUNCE_CLK_CNT, 65536, consecutive stable synchronised cycles required to accept a level change (>=2)
SYNC_STAGES, 2, flip-flop stages of the input synchroniser per channel (>=2)
ACTIVE_LOW, 0, 1 = raw input inverted before synchronising (pressed = pin low)
LONG_PRESS_CLK_CNT, 0, cycles of accepted-pressed state before btn_long fires; 0 disables long-press logic

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  synchronous, active-high reset
btn_in  input  NUM_BTNS  raw asynchronous button pins, bit i = channel i
btn_state  output  NUM_BTNS  debounced level, 1 = pressed (after polarity)
btn_press  output  NUM_BTNS  one-cycle pulse when btn_state rises
btn_release  output  NUM_BTNS  one-cycle pulse when btn_state falls
btn_long  output  NUM_BTNS  one-cycle pulse after LONG_PRESS_CLK_CNT cycles of continuous btn_state=1

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high. All state changes occur on posedge clk.
- Reset values: btn_state=0, btn_press=0, btn_release=0, btn_long=0. Synchroniser stages reset to the released level (0 after polarity). Debounce and long-press counters reset to 0.
- Reset mid-operation: any partial count is discarded. After reset deasserts, a held button must re-qualify fully, i.e. SYNC_STAGES + DEBOUNCE_CLK_CNT edges, before btn_state=1.
- Polarity: lvl_i = btn_in[i] XOR ACTIVE_LOW, applied before the first synchroniser flop.
- Synchroniser: a SYNC_STAGES-deep shift register. s_i is the last-stage output. No logic between stages.
- Debounce counter: width $clog2(DEBOUNCE_CLK_CNT), one per channel.
  - If s_i == btn_state[i]: cnt <= 0.
  - Else if cnt < DEBOUNCE_CLK_CNT-1: cnt <= cnt+1.
  - Else: btn_state[i] <= s_i and cnt <= 0.
  - This is symmetric: release is debounced exactly like press.
- Latency: btn_state flips on the edge that samples the DEBOUNCE_CLK_CNT-th consecutive cycle with s_i != btn_state. Measured from the first edge that samples the new raw level, this is SYNC_STAGES + DEBOUNCE_CLK_CNT edges.
- Bounce: any single-cycle return of s_i to btn_state clears cnt. There is no hysteresis beyond the counter.
- Pulses: registered, asserted for exactly one cycle, in the same cycle btn_state first shows the new value.
  - btn_press when btn_state goes 0->1.
  - btn_release when btn_state goes 1->0.
  - press and release are never both high on one channel.
- Long press (LONG_PRESS_CLK_CNT>0):
  - Counter width $clog2(LONG_PRESS_CLK_CNT+1), cleared whenever btn_state=0.
  - Increments while btn_state=1 and saturates at LONG_PRESS_CLK_CNT.
  - btn_long pulses once, in the cycle the counter transitions LONG_PRESS_CLK_CNT-1 -> LONG_PRESS_CLK_CNT.
  - It never repeats until the button is released and re-pressed.
  - A release before the threshold means no btn_long.
- Long press (LONG_PRESS_CLK_CNT=0): long-press logic is not generated and btn_long is tied to 0.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- Counters never wrap: the debounce counter stops at DEBOUNCE_CLK_CNT-1, and the long counter saturates.
- Elaboration-time check: error if DEBOUNCE_CLK_CNT<2, SYNC_STAGES<2 or NUM_BTNS<1.

Decomposition:
- Shared package btn_pkg:
  - default constants (DEBOUNCE default 65536, SYNC default 2)
  - function clog2_min1 for counter widths (minimum result 1)
- Sub-module debounce_channel contains the per-channel synchroniser, debounce counter, edge pulses and long-press counter.
- Top level holds only a generate loop over NUM_BTNS instances of debounce_channel.

Test Plan:
- Clean press, bench params NUM_BTNS=2, DEBOUNCE_CLK_CNT=4, SYNC_STAGES=2, LONG_PRESS_CLK_CNT=10.
  - Stimulus: btn_in[0] 0->1 and held.
  - Required: btn_state[0]=1 exactly 6 edges later, btn_press[0] high for that one cycle, channel 1 unchanged.
- Bounce: btn_in[0] = 1,1,1,0,1,1,1,1 … -> cnt clears on the 0; btn_state rises 6 edges after the last 0->1, with a single btn_press pulse.
- Release debounce: with state=1, drive btn_in[0]=0 held -> btn_state falls 6 edges later with one btn_release pulse. A 3-cycle low glitch produces no change.
- Long press:
  - Hold pressed -> btn_long[0] pulses once exactly 10 cycles after btn_state rose, then stays 0 while held.
  - A release after 9 cycles gives no btn_long.
- Reset mid-count: assert reset for 1 cycle while cnt=2 -> all outputs 0 next cycle; the held button needs the full 6 edges after reset drops.
- ACTIVE_LOW=1 with both channels switched simultaneously -> pin low is treated as pressed, and both btn_press bits pulse in the same cycle.
